mux_n_para_1_reg: RTL and testbench

- Parametrised, registered N:1 word selector for the ULA result path, generalising the fixed 8-input, 8-bit result mux.
- Selects one of N_IN operand/result words by S and adds Zero, Negative and invalid-select flags.
- Registers the selected word behind a valid/ready handshake, with a 2-entry skid buffer so full throughput holds under backpressure.
- Sits between the ULA functional units and the accumulator/display stage.

---
 rtl/mux_n_para_1_reg.sv | 127 ++++++++++++
 tb/tb_mux_n_para_1_reg.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_para_1_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : mux_n_para_1_reg                                             |
// | Purpose : registered N:1 word selector with Z/N/ERR flags behind a     |
// |           valid/ready handshake and a two-entry skid buffer.           |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module mux_n_para_1_reg #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 8,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] D,
    input  logic [SEL_W-1:0]      S,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      Y,
    output logic [SEL_W-1:0]      S_OUT,
    output logic                  Z,
    output logic                  N,
    output logic                  ERR,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [SEL_W-1:0] s;
        logic             z;
        logic             n;
        logic             err;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam entry_t c_reset_entry = '{y: '0, s: '0, z: 1'b1, n: 1'b0, err: 1'b0};

    state_t           state_q, state_d;
    entry_t           out_q, out_d;
    entry_t           skid_q, skid_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] w_sel_word;
    logic             w_err;
    entry_t           w_new;
    logic             w_acc;
    logic             w_pop;

    // Only in-range selects can match, so an out-of-range select yields a zero word.
    always_comb begin
        w_sel_word = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (S == SEL_W'(i)) begin
                w_sel_word = D[i*WIDTH +: WIDTH];
            end
        end
        w_err     = (32'(S) >= 32'(N_IN));
        w_new.y   = w_sel_word;
        w_new.s   = S;
        w_new.z   = (w_sel_word == '0);
        w_new.n   = w_sel_word[WIDTH-1];
        w_new.err = w_err;
    end

    assign w_acc = in_valid && in_ready_q;
    assign w_pop = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_acc) begin
                    out_d   = w_new;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_acc && w_pop) begin
                    out_d = w_new;
                end else if (w_acc) begin
                    skid_d  = w_new;
                    state_d = ST_FULL;
                end else if (w_pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_q      <= c_reset_entry;
            skid_q     <= c_reset_entry;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign Y         = out_q.y;
    assign S_OUT     = out_q.s;
    assign Z         = out_q.z;
    assign N         = out_q.n;
    assign ERR       = out_q.err;

endmodule
`default_nettype wire

// File: tb/tb_mux_n_para_1_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_mux_n_para_1_reg                                          |
// | Purpose : scoreboard bench for mux_n_para_1_reg (WIDTH=8, N_IN=6).     |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_mux_n_para_1_reg;

    localparam int W  = 8;
    localparam int NI = 6;
    localparam int SW = 3;

    typedef struct packed {
        logic [W-1:0]  y;
        logic [SW-1:0] s;
        logic          z;
        logic          n;
        logic          err;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NI*W-1:0] D = '0;
    logic [SW-1:0]   S = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    Y;
    logic [SW-1:0]   S_OUT;
    logic            Z, N, ERR;
    logic            out_valid;
    logic            out_ready = 1'b0;

    ent_t r_exp = '0;
    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    mux_n_para_1_reg #(.WIDTH(W), .N_IN(NI), .SEL_W(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .D        (D),
        .S        (S),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Y        (Y),
        .S_OUT    (S_OUT),
        .Z        (Z),
        .N        (N),
        .ERR      (ERR),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic ent_t mk(logic [W-1:0] y, logic [SW-1:0] s, logic err);
        return '{y, s, (y == '0), y[W-1], err};
    endfunction

    function automatic ent_t model(logic [SW-1:0] s, logic [NI*W-1:0] d);
        if (int'(s) >= NI) return mk('0, s, 1'b1);
        return mk(d[int'(s)*W +: W], s, 1'b0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    // Accepted words enter the scoreboard just after the falling edge.
    always @(negedge clk) begin
        #1;
        if (!rst && in_valid && in_ready) q.push_back(r_exp);
    end

    // Monitor: every presented word must match the queue head; it pops on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL out_spurious: got y=%h s=%0d with empty queue, want no output", Y, S_OUT);
            end else begin
                if ({Y, S_OUT, Z, N, ERR} !== q[0]) begin
                    errors++;
                    $display("FAIL out_word: got y=%h s=%0d z=%b n=%b err=%b, want y=%h s=%0d z=%b n=%b err=%b",
                             Y, S_OUT, Z, N, ERR, q[0].y, q[0].s, q[0].z, q[0].n, q[0].err);
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic send(input logic [SW-1:0] s, input logic [NI*W-1:0] d, input ent_t e);
        bit done = 1'b0;
        S = s; D = d; r_exp = e; in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept, want accept within 50 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 20 && q.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_y"}, 32'(Y), 0);
        chk({nm, "_sout"}, 32'(S_OUT), 0);
        chk({nm, "_z"}, 32'(Z), 1);
        chk({nm, "_n"}, 32'(N), 0);
        chk({nm, "_err"}, 32'(ERR), 0);
        chk({nm, "_ovalid"}, 32'(out_valid), 0);
        chk({nm, "_iready"}, 32'(in_ready), 1);
    endtask

    initial begin
        logic [NI*W-1:0] d;
        logic [SW-1:0]   s;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        out_ready = 1'b1;

        // Basic select: word i = 8'h10+i, S=5
        for (int i = 0; i < NI; i++) d[i*W +: W] = 8'h10 + 8'(i);
        send(3'd5, d, mk(8'h15, 3'd5, 1'b0));
        #1;
        chk("basic_ovalid_hi", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        chk("basic_ovalid_lo", 32'(out_valid), 0);

        // Flags and out-of-range
        d = 48'h0000_0000_0000;
        d[2*W +: W] = 8'h80;
        d[0 +: W]   = 8'h5A;
        send(3'd2, d, mk(8'h80, 3'd2, 1'b0));
        send(3'd3, d, mk(8'h00, 3'd3, 1'b0));
        send(3'd7, d, mk(8'h00, 3'd7, 1'b1));
        drain();

        // Backpressure and skid
        out_ready = 1'b0;
        d = 48'hC3C3_B2B2_A1A1;
        send(3'd0, d, mk(8'hA1, 3'd0, 1'b0));
        send(3'd2, d, mk(8'hB2, 3'd2, 1'b0));
        S = 3'd4; D = d; r_exp = mk(8'hC3, 3'd4, 1'b0); in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("skid_iready_lo", 32'(in_ready), 0);
        chk("skid_hold_y", 32'(Y), 32'h0000_00A1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(3'd4, d, mk(8'hC3, 3'd4, 1'b0));
        drain();

        // Reset while FULL discards both entries
        out_ready = 1'b0;
        send(3'd1, 48'h0000_0000_7F00, mk(8'h7F, 3'd1, 1'b0));
        send(3'd1, 48'h0000_0000_FF00, mk(8'hFF, 3'd1, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Streaming at full rate
        for (int k = 0; k < 100; k++) begin
            s = 3'($urandom_range(0, 7));
            d = 48'({$urandom(), $urandom()});
            S = s; D = d; r_exp = model(s, d); in_valid = 1'b1;
            @(negedge clk);
            chk("stream_iready", 32'(in_ready), 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stream_latency", q.size(), 0);

        // Random handshake with a mid-run reset
        for (int c = 0; c < 1000; c++) begin
            if (c == 500) begin
                rst = 1'b1;
                in_valid = 1'b0;
                #1;
                chk("mid_rst_ovalid", 32'(out_valid), 0);
                chk("mid_rst_iready", 32'(in_ready), 1);
                q.delete();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            s = 3'($urandom_range(0, 7));
            d = 48'({$urandom(), $urandom()});
            S = s; D = d; r_exp = model(s, d);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
